// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard beside decode.
// Counts in-flight writers per architectural register and raises a decode
// stall on a RAW hazard (a source with an outstanding writer) or when the
// destination counter is already at its maximum.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid/id_rs/id_rt/...   decode instruction (sources, destination)
//   wb_valid/wb_rd/wb_we       writeback release of a destination
//   sq_valid/sq_rd             squash release of one killed writer
//   stall                      combinational decode stall
//   pending                    per-register "count != 0" from registered state
//   err                        sticky: release seen against a zero count
//
// Optional build macro HAZARD_SCOREBOARD_STALL_CNT_EN adds a saturating
// 16-bit stall cycle counter (stall_cycles) with synchronous clear
// (stall_cnt_clr, priority over increment).

module hazard_scoreboard #(
    parameter int unsigned NREG      = 8,
    parameter int unsigned RW        = 3,
    parameter int unsigned CW        = 2,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic            id_rs_used,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_rt_used,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_rd_we,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic            wb_we,
    input  logic            sq_valid,
    input  logic [RW-1:0]   sq_rd,
    output logic            stall,
    output logic [NREG-1:0] pending,
    output logic            err
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    ,
    input  logic            stall_cnt_clr,
    output logic [15:0]     stall_cycles
`endif
);

    // Sum width: one extra bit so count + issue never wraps.
    localparam int unsigned SW = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    ret, sq, raw, full, issue;
    logic [NREG-1:0]         ret_hit, sq_hit, inc_hit, busy, uflow;
    logic [NREG-1:0][SW-1:0] sum_w, dec_w;

    // Per-register event decode, hazard detection and next-state counts.
    always_comb begin
        ret     = wb_valid & wb_we;
        sq      = sq_valid;
        ret_hit = '0;
        sq_hit  = '0;
        inc_hit = '0;
        busy    = '0;
        uflow   = '0;
        sum_w   = '0;
        dec_w   = '0;
        pending = '0;
        cnt_d   = cnt_q;

        for (int unsigned r = 0; r < NREG; r++) begin
            ret_hit[r] = ret && (wb_rd == RW'(r));
            sq_hit[r]  = sq  && (sq_rd == RW'(r));
            dec_w[r]   = SW'(ret_hit[r]) + SW'(sq_hit[r]);
            busy[r]    = (cnt_q[r] != '0);
            pending[r] = (cnt_q[r] != '0);
            // Write-through register file: the last outstanding writer
            // retiring this cycle already makes the value visible.
            if ((WB_BYPASS != 0) && ret_hit[r] && (SW'(cnt_q[r]) == dec_w[r])) begin
                busy[r] = 1'b0;
            end
        end

        raw   = id_valid & ((id_rs_used & busy[id_rs]) | (id_rt_used & busy[id_rt]));
        full  = id_valid & id_rd_we & (cnt_q[id_rd] == CNT_MAX);
        stall = raw | full;
        issue = id_valid & id_rd_we & ~stall;

        for (int unsigned r = 0; r < NREG; r++) begin
            inc_hit[r] = issue && (id_rd == RW'(r));
            sum_w[r]   = SW'(cnt_q[r]) + SW'(inc_hit[r]);
            // Releases that would take the count below zero are dropped.
            if (sum_w[r] < dec_w[r]) begin
                uflow[r] = 1'b1;
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = CW'(sum_w[r] - dec_w[r]);
            end
        end

        err_d = err_q | (|uflow);
        err   = err_q;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_cnt_clr) begin
            stall_cycles_d = '0;
        end else if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        stall_cycles = stall_cycles_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end
`endif

endmodule
